// File: rtl/kyber_pkg.sv
// Shared Kyber constants, the BRAM-pair lane permutation and the reorder bank-state encoding.
package kyber_pkg;

  localparam int KYBER_N = 256;
  localparam int KYBER_Q = 3329;
  localparam int COEF_W  = 12;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  // Position within a group of four that the r-th memory-order beat belongs to.
  function automatic logic [1:0] kyber_perm4(input logic [1:0] r);
    case (r)
      2'd1:    return 2'd2;
      2'd2:    return 2'd1;
      default: return r;
    endcase
  endfunction

endpackage

// File: rtl/kyber_reorder_bank.sv
// One polynomial of reorder storage: PE scattered write ports, PE consecutive registered read ports.
module kyber_reorder_bank
  import kyber_pkg::*;
#(
  parameter int PE_NUMBER = 1,
  parameter int COEF_W    = 12,
  parameter int N         = KYBER_N,
  localparam int AW       = $clog2(N),
  localparam int RW       = $clog2(N / PE_NUMBER)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              we,
  input  logic [PE_NUMBER-1:0][AW-1:0]      wr_addr,
  input  logic [PE_NUMBER-1:0][COEF_W-1:0]  wr_data,
  input  logic                              re,
  input  logic [RW-1:0]                     rd_beat,
  output logic [PE_NUMBER-1:0][COEF_W-1:0]  rd_data
);

  logic [COEF_W-1:0] mem [N];

  // Storage is intentionally not reset; every location is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < PE_NUMBER; l++) mem[wr_addr[l]] <= wr_data[l];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (re) begin
      for (int l = 0; l < PE_NUMBER; l++)
        rd_data[l] <= mem[AW'(int'(rd_beat) * PE_NUMBER + l)];
    end
  end

endmodule

// File: rtl/kyber_ntt_out_reorder.sv
// Streaming reorder from BRAM-pair order to natural order, PE_NUMBER lanes per beat.
// Define KYBER_REORDER_PINGPONG_EN for two banks so consecutive polynomials overlap.
module kyber_ntt_out_reorder
  import kyber_pkg::*;
#(
  parameter int PE_NUMBER = 1,
  parameter int COEF_W    = 12,
  parameter int N         = KYBER_N
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [COEF_W*PE_NUMBER-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COEF_W*PE_NUMBER-1:0]   out_data,
  output logic                          out_last,
  output logic                          busy
);

  localparam int NB  = N / PE_NUMBER;
  localparam int AW  = $clog2(N);
  localparam int CW  = $clog2(NB);
  localparam int RCW = $clog2(NB + 1);
`ifdef KYBER_REORDER_PINGPONG_EN
  localparam bit PINGPONG = 1'b1;
`else
  localparam bit PINGPONG = 1'b0;
`endif
  localparam int NBANK = PINGPONG ? 2 : 1;

  bank_state_e st_q [2];
  bank_state_e st_d [2];
  logic           wb_q, rb_q, wb_d, rb_d, rd_sel_q, ld_bank;
  logic [CW-1:0]  wr_cnt_q, rd_beat;
  logic [RCW-1:0] rd_cnt_q;
  logic           in_fire, wr_done, last_fire, load;

  logic [PE_NUMBER-1:0][AW-1:0]     wr_addr;
  logic [PE_NUMBER-1:0][COEF_W-1:0] wr_lane;
  logic [PE_NUMBER-1:0][COEF_W-1:0] rd_data [2];

  assign in_fire   = in_valid && in_ready;
  assign wr_done   = in_fire && (wr_cnt_q == CW'(NB - 1));
  assign last_fire = out_valid && out_ready && out_last;

  // When the draining bank has presented every beat, the next load may come from the other bank,
  // which lets a full second polynomial start in the same cycle the first one's last beat leaves.
  assign ld_bank = (PINGPONG && st_q[rb_q] == BANK_DRAINING && rd_cnt_q == RCW'(NB)) ? ~rb_q : rb_q;
  assign load    = (!out_valid || out_ready) &&
                   ((st_q[ld_bank] == BANK_FULL) ||
                    (st_q[ld_bank] == BANK_DRAINING && rd_cnt_q != RCW'(NB)));
  assign rd_beat = (st_q[ld_bank] == BANK_FULL) ? '0 : rd_cnt_q[CW-1:0];

  for (genvar l = 0; l < PE_NUMBER; l++) begin : g_lane
    assign wr_addr[l] = AW'((int'(wr_cnt_q >> 2) * PE_NUMBER + l) * 4 +
                            int'(kyber_perm4(wr_cnt_q[1:0])));
    assign wr_lane[l] = in_data[COEF_W*l +: COEF_W];
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    if (b < NBANK) begin : g_inst
      kyber_reorder_bank #(
        .PE_NUMBER (PE_NUMBER),
        .COEF_W    (COEF_W),
        .N         (N)
      ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .we      (in_fire && wb_q == 1'(b)),
        .wr_addr (wr_addr),
        .wr_data (wr_lane),
        .re      (load && ld_bank == 1'(b)),
        .rd_beat (rd_beat),
        .rd_data (rd_data[b])
      );
    end else begin : g_none
      assign rd_data[b] = '0;
    end
  end

  always_comb begin
    st_d = st_q;
    wb_d = wb_q;
    rb_d = rb_q;
    if (in_fire) begin
      if (wr_done) begin
        st_d[wb_q] = BANK_FULL;
        if (PINGPONG) wb_d = ~wb_q;
      end else begin
        st_d[wb_q] = BANK_FILLING;
      end
    end
    if (load && st_q[ld_bank] == BANK_FULL) st_d[ld_bank] = BANK_DRAINING;
    if (last_fire) begin
      st_d[rb_q] = BANK_EMPTY;
      if (PINGPONG) rb_d = ~rb_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      st_q      <= '{default: BANK_EMPTY};
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
      rd_sel_q  <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      in_ready  <= !reset;
    end else begin
      st_q     <= st_d;
      wb_q     <= wb_d;
      rb_q     <= rb_d;
      in_ready <= (st_d[wb_d] == BANK_EMPTY) || (st_d[wb_d] == BANK_FILLING);
      if (in_fire) wr_cnt_q <= wr_done ? '0 : wr_cnt_q + 1'b1;
      if (load) begin
        rd_cnt_q  <= RCW'(rd_beat) + RCW'(1);
        rd_sel_q  <= ld_bank;
        out_valid <= 1'b1;
        out_last  <= (rd_beat == CW'(NB - 1));
      end else begin
        if (last_fire) rd_cnt_q <= '0;
        if (out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end
    end
  end

  assign out_data = rd_data[rd_sel_q];
  assign busy     = (st_q[0] != BANK_EMPTY) || (st_q[1] != BANK_EMPTY);

endmodule

// File: tb/tb_kyber_ntt_out_reorder.sv
// Bench for kyber_ntt_out_reorder: a PE=1 and a PE=2 instance checked against a natural-order model.
module tb_kyber_ntt_out_reorder;

  localparam int N = 256;
  localparam int W = 12;

  logic clk = 1'b0;
  logic reset, clear;
  logic [1:0] iv, ordy;
  wire  [1:0] ir, ov, ol, bz;
  logic [W-1:0]   id0;
  logic [2*W-1:0] id1;
  wire  [W-1:0]   od0;
  wire  [2*W-1:0] od1;

  int vectors = 0, miscompares = 0, tick = 0;
  logic [2*W-1:0] in_q[$];
  logic [2*W:0]   exp_q[$];
  int acc_t[$], out_t[$];
  int ir_drop, first_ov;
  int perm[4] = '{0, 2, 1, 3};

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  kyber_ntt_out_reorder #(.PE_NUMBER(1), .COEF_W(W), .N(N)) dut1 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id0),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0),
    .out_last(ol[0]), .busy(bz[0]));

  kyber_ntt_out_reorder #(.PE_NUMBER(2), .COEF_W(W), .N(N)) dut2 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id1),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1),
    .out_last(ol[1]), .busy(bz[1]));

  function automatic logic [2*W-1:0] get_od(input int s);
    return (s == 1) ? od1 : {{W{1'b0}}, od0};
  endfunction

  task automatic set_id(input int s, input logic [2*W-1:0] v);
    if (s == 1) id1 = v;
    else id0 = v[W-1:0];
  endtask

  // Model: the polynomial p in natural order is the expected stream; the input stream is p
  // presented in BRAM-pair memory order.
  task automatic load_poly(input int s, input int base, input bit rnd);
    int pe = s + 1;
    int nb = N / pe;
    logic [W-1:0] p [N];
    logic [2*W-1:0] b;
    logic [2*W:0] e;
    for (int i = 0; i < N; i++) p[i] = rnd ? W'($urandom_range(0, 4095)) : W'(base + i);
    for (int c = 0; c < nb; c++) begin
      b = '0;
      for (int l = 0; l < pe; l++) b[W*l +: W] = p[4*((c/4)*pe + l) + perm[c%4]];
      in_q.push_back(b);
    end
    for (int j = 0; j < nb; j++) begin
      e = '0;
      for (int l = 0; l < pe; l++) e[W*l +: W] = p[j*pe + l];
      e[2*W] = (j == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic run(input int s, input int rdy_pct, input int max_in, input int max_out,
                     input int budget);
    int n_in = 0, n_out = 0, cyc = 0;
    bit stalled = 1'b0;
    logic [2*W-1:0] held = '0;
    logic held_last = 1'b0;
    logic [2*W:0] e;
    acc_t.delete(); out_t.delete(); ir_drop = 0; first_ov = -1;
    while ((in_q.size() > 0 && n_in < max_in) || (exp_q.size() > 0 && n_out < max_out)) begin
      @(negedge clk);
      cyc++;
      if (cyc > budget) begin
        vectors++; miscompares++;
        $display("FAIL timeout dut%0d: %0d in beats and %0d out beats left after %0d cycles",
                 s, in_q.size(), exp_q.size(), budget);
        break;
      end
      if (stalled) begin
        vectors++;
        if (ov[s] !== 1'b1 || get_od(s) !== held || ol[s] !== held_last) begin
          miscompares++;
          $display("FAIL stall_hold dut%0d: got valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                   s, ov[s], get_od(s), ol[s], held, held_last);
        end
      end
      if (ov[s] === 1'b1 && first_ov < 0) first_ov = tick;
      if (in_q.size() > 0 && n_in < max_in) begin
        iv[s] = 1'b1;
        set_id(s, in_q[0]);
        if (ir[s] === 1'b1) begin
          void'(in_q.pop_front()); n_in++; acc_t.push_back(tick);
        end else ir_drop++;
      end else iv[s] = 1'b0;
      ordy[s] = (exp_q.size() > 0) && (n_out < max_out) && ($urandom_range(0, 99) < rdy_pct);
      stalled = (ov[s] === 1'b1) && !ordy[s];
      held = get_od(s);
      held_last = ol[s];
      if (ov[s] === 1'b1 && ordy[s]) begin
        e = exp_q.pop_front();
        vectors++; n_out++; out_t.push_back(tick);
        if (get_od(s) !== e[2*W-1:0] || ol[s] !== e[2*W]) begin
          miscompares++;
          $display("FAIL out_beat dut%0d beat %0d: got data=%h last=%b, want data=%h last=%b",
                   s, n_out - 1, get_od(s), ol[s], e[2*W-1:0], e[2*W]);
        end
      end
    end
    @(negedge clk);
    iv[s] = 1'b0;
    ordy[s] = 1'b0;
    if (in_q.size() == 0 && exp_q.size() == 0) begin
      vectors++;
      if (ov[s] !== 1'b0 || bz[s] !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_after dut%0d: got valid=%b busy=%b, want 0 0", s, ov[s], bz[s]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; iv = '0; ordy = '0; id0 = '0; id1 = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if (ir[s] !== 1'b0 || ov[s] !== 1'b0 || ol[s] !== 1'b0 || bz[s] !== 1'b0 || get_od(s) !== '0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: got ready=%b valid=%b last=%b busy=%b data=%h, want all 0",
                 s, ir[s], ov[s], ol[s], bz[s], get_od(s));
      end
    end
    reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if (ir[s] !== 1'b1 || bz[s] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_release dut%0d: got ready=%b busy=%b, want 1 0", s, ir[s], bz[s]);
      end
    end
  endtask

  task automatic test_pe1_order();
    load_poly(0, 0, 1'b0);
    run(0, 100, 1 << 30, 1 << 30, 2000);
    vectors++;
    if (acc_t.size() != N || first_ov - acc_t[N-1] != 2) begin
      miscompares++;
      $display("FAIL pe1_latency: got %0d cycles (%0d beats in), want 2", first_ov - acc_t[acc_t.size()-1],
               acc_t.size());
    end
  endtask

  task automatic test_pe2_order();
    load_poly(1, 0, 1'b0);
    run(1, 100, 1 << 30, 1 << 30, 2000);
    vectors++;
    if (acc_t.size() != N/2 || out_t.size() != N/2) begin
      miscompares++;
      $display("FAIL pe2_beats: got %0d in / %0d out, want 128 / 128", acc_t.size(), out_t.size());
    end
  endtask

  task automatic test_random_stall();
    load_poly(1, 0, 1'b1);
    run(1, 50, 1 << 30, 1 << 30, 4000);
  endtask

  task automatic test_back_to_back();
    load_poly(0, 0, 1'b1);
    load_poly(0, 0, 1'b1);
    run(0, 100, 1 << 30, 1 << 30, 4000);
    vectors++;
    if (out_t.size() != 2*N || out_t[N] - acc_t[2*N-1] != 2 || out_t[2*N-1] - out_t[N] != N - 1) begin
      miscompares++;
      $display("FAIL b2b_second_out: got %0d out beats, start offset %0d, span %0d; want 512, 2, 255",
               out_t.size(), out_t[N] - acc_t[acc_t.size()-1], out_t[out_t.size()-1] - out_t[N]);
    end
    vectors++;
`ifdef KYBER_REORDER_PINGPONG_EN
    if (ir_drop != 0) begin
      miscompares++;
      $display("FAIL b2b_in_ready: got %0d stalled input cycles, want 0", ir_drop);
    end
`else
    if (acc_t[N] - acc_t[N-1] < N + 2) begin
      miscompares++;
      $display("FAIL b2b_gap: got %0d cycles between polys, want >= %0d", acc_t[N] - acc_t[N-1], N + 2);
    end
`endif
  endtask

  task automatic test_clear();
    load_poly(0, 0, 1'b1);
    run(0, 100, 100, 0, 1000);
    clear = 1'b1;
    iv[0] = 1'b1;
    id0 = 12'hABC;
    @(negedge clk);
    clear = 1'b0;
    iv[0] = 1'b0;
    vectors++;
    if (ov[0] !== 1'b0 || bz[0] !== 1'b0 || ir[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_state: got valid=%b busy=%b ready=%b, want 0 0 1", ov[0], bz[0], ir[0]);
    end
    in_q.delete();
    exp_q.delete();
    load_poly(0, 1000, 1'b0);
    run(0, 100, 1 << 30, 1 << 30, 2000);
  endtask

  task automatic test_reset_mid_drain();
    load_poly(1, 0, 1'b1);
    run(1, 100, 1 << 30, 50, 1000);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (ov[1] !== 1'b0 || bz[1] !== 1'b0 || ir[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got valid=%b busy=%b ready=%b, want 0 0 0", ov[1], bz[1], ir[1]);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (ir[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_ready: got ready=%b, want 1", ir[1]);
    end
    in_q.delete();
    exp_q.delete();
    load_poly(1, 0, 1'b1);
    run(1, 100, 1 << 30, 1 << 30, 2000);
  endtask

  initial begin
    test_reset();
    test_pe1_order();
    test_pe2_order();
    test_random_stall();
    test_back_to_back();
    test_clear();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
